line_scheduler: RTL

Sequencing controller for the VGA line-drawing datapath. It owns the single line drawer and framebuffer write path and shares them between two requesters: a full-screen clear, swept as one black vertical line per column, and a segment animation. On each animation tick it erases the previously drawn segment in black, then draws the next segment from an external segment ROM in white. It sits between the top-level user inputs and timebase and the line drawer / framebuffer.

---
 rtl/line_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/line_scheduler.sv
// Sequencer that shares the single line drawer between the full-screen clear sweep
// and the erase/draw segment animation. All outputs are registered.
module line_scheduler #(
  parameter int NUM_SEGS = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear_req,
  input  logic       run,
  input  logic       tick,
  output logic [3:0] seg_addr,
  input  logic [9:0] seg_x0,
  input  logic [9:0] seg_x1,
  input  logic [8:0] seg_y0,
  input  logic [8:0] seg_y1,
  output logic       draw_start,
  input  logic       draw_done,
  output logic [9:0] x0,
  output logic [9:0] x1,
  output logic [8:0] y0,
  output logic [8:0] y1,
  output logic       pixel_color,
  output logic       pixel_write,
  output logic       busy,
  output logic       tick_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CLR_ISSUE,
    CLR_WAIT,
    FETCH,
    ERASE_ISSUE,
    ERASE_WAIT,
    DRAW_ISSUE,
    DRAW_WAIT
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(SCREEN_W - 1);
  localparam logic [8:0] LAST_ROW = 9'(SCREEN_H - 1);
  localparam logic [3:0] LAST_SEG = 4'(NUM_SEGS - 1);

  state_t     state, state_d;
  logic [9:0] col, col_d;
  logic [3:0] idx, idx_d;
  logic [9:0] prev_x0, prev_x1, prev_x0_d, prev_x1_d;
  logic [8:0] prev_y0, prev_y1, prev_y0_d, prev_y1_d;
  logic [9:0] new_x0, new_x1, new_x0_d, new_x1_d;
  logic [8:0] new_y0, new_y1, new_y0_d, new_y1_d;
  logic       has_prev, has_prev_d;
  logic       clr_pend, clr_pend_d;

  logic       draw_start_d, pixel_color_d, pixel_write_d, busy_d, tick_overrun_d;
  logic [9:0] x0_d, x1_d;
  logic [8:0] y0_d, y1_d;

  logic       tick_req;
  logic       in_clear;

  assign tick_req = tick && run;
  assign in_clear = (state == CLR_ISSUE) || (state == CLR_WAIT);
  assign seg_addr = idx;

  // Next-state logic plus the bookkeeping registers updated on line completion.
  always_comb begin
    state_d    = state;
    col_d      = col;
    idx_d      = idx;
    prev_x0_d  = prev_x0;
    prev_y0_d  = prev_y0;
    prev_x1_d  = prev_x1;
    prev_y1_d  = prev_y1;
    new_x0_d   = new_x0;
    new_y0_d   = new_y0;
    new_x1_d   = new_x1;
    new_y1_d   = new_y1;
    has_prev_d = has_prev;
    clr_pend_d = clr_pend;

    case (state)
      IDLE: begin
        if (clear_req || clr_pend) begin
          col_d      = 10'd0;
          clr_pend_d = 1'b0;
          state_d    = CLR_ISSUE;
        end else if (tick_req) begin
          state_d = FETCH;
        end
      end
      CLR_ISSUE: state_d = CLR_WAIT;
      CLR_WAIT: begin
        if (draw_done) begin
          if (col == LAST_COL) begin
            has_prev_d = 1'b0;
            idx_d      = 4'd0;
            state_d    = IDLE;
          end else begin
            col_d   = col + 10'd1;
            state_d = CLR_ISSUE;
          end
        end
      end
      FETCH: begin
        new_x0_d = seg_x0;
        new_y0_d = seg_y0;
        new_x1_d = seg_x1;
        new_y1_d = seg_y1;
        state_d  = has_prev ? ERASE_ISSUE : DRAW_ISSUE;
      end
      ERASE_ISSUE: state_d = ERASE_WAIT;
      ERASE_WAIT: begin
        if (draw_done) state_d = DRAW_ISSUE;
      end
      DRAW_ISSUE: state_d = DRAW_WAIT;
      DRAW_WAIT: begin
        if (draw_done) begin
          prev_x0_d  = new_x0;
          prev_y0_d  = new_y0;
          prev_x1_d  = new_x1;
          prev_y1_d  = new_y1;
          has_prev_d = 1'b1;
          idx_d      = (idx == LAST_SEG) ? 4'd0 : idx + 4'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear arriving mid-animation waits for the in-flight line and starts from IDLE.
    if (clear_req && (state != IDLE) && !in_clear) clr_pend_d = 1'b1;
  end

  // Output values for the coming cycle, decoded from the next state so they register cleanly.
  always_comb begin
    draw_start_d   = (state_d == CLR_ISSUE) || (state_d == ERASE_ISSUE) ||
                     (state_d == DRAW_ISSUE);
    pixel_write_d  = (state_d != IDLE) && (state_d != FETCH);
    pixel_color_d  = (state_d == DRAW_ISSUE) || (state_d == DRAW_WAIT);
    busy_d         = (state_d != IDLE);
    tick_overrun_d = tick_req && ((state != IDLE) || clr_pend || clear_req);
    x0_d           = x0;
    y0_d           = y0;
    x1_d           = x1;
    y1_d           = y1;

    case (state_d)
      CLR_ISSUE: begin
        x0_d = col_d;
        y0_d = 9'd0;
        x1_d = col_d;
        y1_d = LAST_ROW;
      end
      ERASE_ISSUE: begin
        x0_d = prev_x0;
        y0_d = prev_y0;
        x1_d = prev_x1;
        y1_d = prev_y1;
      end
      DRAW_ISSUE: begin
        x0_d = new_x0_d;
        y0_d = new_y0_d;
        x1_d = new_x1_d;
        y1_d = new_y1_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      col          <= '0;
      idx          <= '0;
      prev_x0      <= '0;
      prev_y0      <= '0;
      prev_x1      <= '0;
      prev_y1      <= '0;
      new_x0       <= '0;
      new_y0       <= '0;
      new_x1       <= '0;
      new_y1       <= '0;
      has_prev     <= 1'b0;
      clr_pend     <= 1'b0;
      draw_start   <= 1'b0;
      pixel_color  <= 1'b0;
      pixel_write  <= 1'b0;
      busy         <= 1'b0;
      tick_overrun <= 1'b0;
      x0           <= '0;
      y0           <= '0;
      x1           <= '0;
      y1           <= '0;
    end else begin
      state        <= state_d;
      col          <= col_d;
      idx          <= idx_d;
      prev_x0      <= prev_x0_d;
      prev_y0      <= prev_y0_d;
      prev_x1      <= prev_x1_d;
      prev_y1      <= prev_y1_d;
      new_x0       <= new_x0_d;
      new_y0       <= new_y0_d;
      new_x1       <= new_x1_d;
      new_y1       <= new_y1_d;
      has_prev     <= has_prev_d;
      clr_pend     <= clr_pend_d;
      draw_start   <= draw_start_d;
      pixel_color  <= pixel_color_d;
      pixel_write  <= pixel_write_d;
      busy         <= busy_d;
      tick_overrun <= tick_overrun_d;
      x0           <= x0_d;
      y0           <= y0_d;
      x1           <= x1_d;
      y1           <= y1_d;
    end
  end

endmodule
